// File: rtl/sgdmac_desc_fetch.sv
// rtl/sgdmac_desc_fetch.sv - scatter-gather DMA descriptor fetch and sequencing engine
module sgdmac_desc_fetch #(
    parameter logic [3:0] ARID  = 4'h1,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      desc_ptr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] desc_cnt_o,
    output logic             desc_valid_o,
    input  logic             desc_ready_i,
    output logic [31:0]      desc_src_o,
    output logic [31:0]      desc_dst_o,
    output logic [15:0]      desc_len_o,
    output logic [3:0]       arid_o,
    output logic [31:0]      araddr_o,
    output logic [3:0]       arlen_o,
    output logic [2:0]       arsize_o,
    output logic [1:0]       arburst_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    input  logic [3:0]       rid_i,
    input  logic [31:0]      rdata_i,
    input  logic [1:0]       rresp_i,
    input  logic             rlast_i,
    input  logic             rvalid_i,
    output logic             rready_o
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_OUT, S_FIN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [31:0]      ptr;
    logic [31:0]      src_q, dst_q, next_q;
    logic [15:0]      len_q;
    logic [1:0]       beat_idx;
    logic             burst_err;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             beat_last;
    logic             beat_bad;

    // A beat is last on rlast or on the fourth beat; rlast must coincide with beat 3 exactly.
    assign beat_last = rlast_i || (beat_idx == 2'd3);
    assign beat_bad  = (rresp_i != 2'b00) || (rid_i != ARID) || (rlast_i != (beat_idx == 2'd3));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_i) state_nxt = (desc_ptr_i[3:0] != 4'd0) ? S_FIN : S_ADDR;
            S_ADDR: if (arready_i) state_nxt = S_DATA;
            S_DATA: if (rvalid_i && beat_last) state_nxt = (burst_err || beat_bad) ? S_FIN : S_OUT;
            S_OUT:  if (desc_ready_i) state_nxt = (next_q[31:4] == 28'd0 || next_q[3:0] != 4'd0) ? S_FIN : S_ADDR;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            next_q    <= '0;
            beat_idx  <= '0;
            burst_err <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ptr   <= desc_ptr_i;
                        cnt_q <= '0;
                        err_q <= (desc_ptr_i[3:0] != 4'd0);
                    end
                end
                S_ADDR: begin
                    if (arready_i) begin
                        beat_idx  <= 2'd0;
                        burst_err <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (rvalid_i) begin
                        case (beat_idx)
                            2'd0: src_q  <= rdata_i;
                            2'd1: dst_q  <= rdata_i;
                            2'd2: len_q  <= rdata_i[15:0];
                            2'd3: next_q <= rdata_i;
                        endcase
                        beat_idx <= beat_idx + 2'd1;
                        if (beat_bad) burst_err <= 1'b1;
                        if (beat_last && (burst_err || beat_bad)) err_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (desc_ready_i) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (next_q[3:0] != 4'd0) err_q <= 1'b1;
                        else                     ptr   <= next_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_FIN);
    assign err_o        = err_q;
    assign desc_cnt_o   = cnt_q;
    assign desc_valid_o = (state == S_OUT);
    assign desc_src_o   = src_q;
    assign desc_dst_o   = dst_q;
    assign desc_len_o   = len_q;
    assign arid_o       = ARID;
    assign araddr_o     = ptr;
    assign arlen_o      = 4'd3;
    assign arsize_o     = 3'b010;
    assign arburst_o    = 2'b01;
    assign arvalid_o    = (state == S_ADDR);
    assign rready_o     = (state == S_DATA);
endmodule

// File: tb/tb_sgdmac_desc_fetch.sv
// tb/tb_sgdmac_desc_fetch.sv - self-checking bench for sgdmac_desc_fetch
module tb_sgdmac_desc_fetch;
    localparam logic [3:0] ARID = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] desc_ptr;
    logic        busy, done, err;
    logic [15:0] desc_cnt;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_src, desc_dst;
    logic [15:0] desc_len;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    sgdmac_desc_fetch #(.ARID(ARID), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .desc_ptr_i(desc_ptr),
        .busy_o(busy), .done_o(done), .err_o(err), .desc_cnt_o(desc_cnt),
        .desc_valid_o(desc_valid), .desc_ready_i(desc_ready),
        .desc_src_o(desc_src), .desc_dst_o(desc_dst), .desc_len_o(desc_len),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
        .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
        .rvalid_i(rvalid), .rready_o(rready)
    );

    always #5 clk = ~clk;

    bit [31:0]   mem [bit [31:0]];
    int          n_pass = 0, n_total = 0;
    bit          slave_en = 1'b1;
    int          ar_stall_max = 0, r_stall_max = 0, rdy_delay = 0;
    int          inj_rel = -1, inj_abs = -1, inj_beat = 0, inj_kind = 0;
    int          burst_no = 0, beats_sent = 0, done_cnt = 0, ar_viol = 0, out_viol = 0;
    logic [31:0] ar_q[$];
    logic [79:0] got_q[$];
    logic [31:0] exp_ar[$];
    logic [79:0] exp_desc[$];
    logic        exp_err;
    int          exp_cnt, exp_beats;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: walk the list in memory by the chain rules, honouring the injected bad burst.
    function automatic void model(input logic [31:0] p);
        bit [31:0] w [4];
        int bn = 0;
        exp_ar.delete();
        exp_desc.delete();
        exp_err = 1'b0;
        exp_cnt = 0;
        exp_beats = 0;
        if (p[3:0] != 4'd0) begin
            exp_err = 1'b1;
            return;
        end
        while (bn < 64) begin
            exp_ar.push_back(p);
            if (bn == inj_rel) begin
                exp_err = 1'b1;
                exp_beats += (inj_kind == 2) ? inj_beat + 1 : 4;
                return;
            end
            exp_beats += 4;
            for (int k = 0; k < 4; k++) w[k] = mem[p + 32'(4 * k)];
            exp_desc.push_back({w[0], w[1], w[2][15:0]});
            exp_cnt++;
            if (w[3] == 32'd0) return;
            if (w[3][3:0] != 4'd0) begin
                exp_err = 1'b1;
                return;
            end
            p = w[3];
            bn++;
        end
    endfunction

    // AXI read slave with random stalls and fault injection
    initial begin
        logic [31:0] addr;
        int st, nb;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = ARID; rlast = 1'b0;
        forever begin
            tick();
            if (slave_en && arvalid) begin
                addr = araddr;
                st = $urandom_range(ar_stall_max, 0);
                repeat (st) tick();
                arready = 1'b1;
                tick();
                arready = 1'b0;
                nb = (burst_no == inj_abs && inj_kind == 2) ? inj_beat + 1 : 4;
                for (int b = 0; b < nb; b++) begin
                    st = $urandom_range(r_stall_max, 0);
                    repeat (st) tick();
                    rvalid = 1'b1;
                    rdata  = mem[addr + 32'(4 * b)];
                    rresp  = (burst_no == inj_abs && inj_kind == 0 && b == inj_beat) ? 2'b10 : 2'b00;
                    rid    = (burst_no == inj_abs && inj_kind == 1 && b == inj_beat) ? 4'h7 : ARID;
                    rlast  = (b == nb - 1);
                    tick();
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = ARID;
                    beats_sent++;
                end
                burst_no++;
            end
        end
    end

    // Descriptor consumer: holds ready low for rdy_delay cycles, checks fields stay stable
    initial begin
        logic [79:0] held;
        int wc;
        desc_ready = 1'b0;
        wc = 0;
        held = '0;
        forever begin
            tick();
            if (desc_ready) desc_ready = 1'b0;
            else if (desc_valid) begin
                if (wc == 0) held = {desc_src, desc_dst, desc_len};
                else if (held !== {desc_src, desc_dst, desc_len}) out_viol++;
                if (wc >= rdy_delay) begin
                    desc_ready = 1'b1;
                    got_q.push_back({desc_src, desc_dst, desc_len});
                    wc = 0;
                end else wc++;
            end
        end
    end

    // AR monitor: address log, constant fields, stability while stalled
    initial begin
        logic pend;
        logic [31:0] paddr;
        pend = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (pend && (!arvalid || araddr !== paddr)) ar_viol++;
            if (arvalid && arready) begin
                ar_q.push_back(araddr);
                if (arlen !== 4'd3 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== ARID) ar_viol++;
            end
            pend  = arvalid && !arready;
            paddr = araddr;
        end
    end

    task automatic run_chain(input logic [31:0] p, input string tag, input bit spur, output int lat);
        int ab, gb, db, ov, av, bb, n;
        logic [79:0] g, e;
        model(p);
        ab = ar_q.size(); gb = got_q.size(); db = done_cnt;
        ov = out_viol; av = ar_viol; bb = beats_sent;
        inj_abs = (inj_rel < 0) ? -1 : burst_no + inj_rel;
        tick();
        start = 1'b1;
        desc_ptr = p;
        tick();
        start = 1'b0;
        @(negedge clk);
        check({tag, "_ar_lat"}, arvalid, (p[3:0] == 4'd0));
        check({tag, "_err_clr"}, err, (p[3:0] != 4'd0));
        if (spur) begin
            start = 1'b1;
            desc_ptr = 32'h900;
            @(negedge clk);
            start = 1'b0;
        end
        lat = 0;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_cnt"}, desc_cnt, exp_cnt);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_clr"}, busy, 0);
        check({tag, "_done_cnt"}, done_cnt - db, 1);
        check({tag, "_beats"}, beats_sent - bb, exp_beats);
        check({tag, "_ar_num"}, ar_q.size() - ab, exp_ar.size());
        n = (ar_q.size() - ab < exp_ar.size()) ? ar_q.size() - ab : exp_ar.size();
        for (int i = 0; i < n; i++) check({tag, "_araddr"}, ar_q[ab + i], exp_ar[i]);
        check({tag, "_desc_num"}, got_q.size() - gb, exp_desc.size());
        n = (got_q.size() - gb < exp_desc.size()) ? got_q.size() - gb : exp_desc.size();
        for (int i = 0; i < n; i++) begin
            g = got_q[gb + i];
            e = exp_desc[i];
            check({tag, "_src"}, g[79:48], e[79:48]);
            check({tag, "_dst"}, g[47:16], e[47:16]);
            check({tag, "_len"}, {16'd0, g[15:0]}, {16'd0, e[15:0]});
        end
        check({tag, "_ar_stable"}, ar_viol - av, 0);
        check({tag, "_out_stable"}, out_viol - ov, 0);
    endtask

    task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] l, input logic [31:0] nx);
        mem[a] = s; mem[a + 4] = d; mem[a + 8] = l; mem[a + 12] = nx;
    endtask

    initial begin
        int lat;
        logic [31:0] a [4];
        rst_n = 1'b0; start = 1'b0; desc_ptr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cnt", desc_cnt, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_dvalid", desc_valid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_ar_const", {arid, arlen, arsize, arburst}, {ARID, 4'd3, 3'b010, 2'b01});

        put_desc(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h0);
        run_chain(32'h100, "single", 1'b0, lat);

        mem.delete();
        put_desc(32'h100, 32'h1100, 32'h2100, 32'hABCD_0010, 32'h200);
        put_desc(32'h200, 32'h1200, 32'h2200, 32'h20, 32'h300);
        put_desc(32'h300, 32'h1300, 32'h2300, 32'h30, 32'h0);
        rdy_delay = 5;
        run_chain(32'h100, "chain3", 1'b1, lat);

        ar_stall_max = 7;
        r_stall_max = 7;
        for (int it = 0; it < 3; it++) begin
            mem.delete();
            for (int i = 0; i < 4; i++)
                a[i] = 32'h0001_0000 + 32'(i * 256) + ($urandom_range(15, 0) << 4);
            for (int i = 0; i < 4; i++)
                put_desc(a[i], $urandom, $urandom, $urandom, (i == 3) ? 32'h0 : a[i + 1]);
            rdy_delay = $urandom_range(3, 0);
            run_chain(a[0], "rand4", 1'b0, lat);
        end

        ar_stall_max = 0; r_stall_max = 2; rdy_delay = 0;
        mem.delete();
        put_desc(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h0);
        inj_rel = 0; inj_beat = 2; inj_kind = 0;
        run_chain(32'h100, "rresp", 1'b0, lat);

        inj_rel = -1;
        run_chain(32'h104, "misalign", 1'b0, lat);
        check("misalign_lat", lat, 0);
        run_chain(32'h100, "restart", 1'b0, lat);

        inj_rel = 0; inj_beat = 1; inj_kind = 2;
        run_chain(32'h100, "rlast_early", 1'b0, lat);

        inj_rel = 1; inj_beat = 3; inj_kind = 1;
        put_desc(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200);
        put_desc(32'h200, 32'h5000, 32'h6000, 32'h80, 32'h0);
        run_chain(32'h100, "bad_rid", 1'b0, lat);

        inj_rel = -1;
        put_desc(32'h200, 32'h5000, 32'h6000, 32'h80, 32'h208);
        run_chain(32'h100, "bad_next", 1'b0, lat);

        slave_en = 1'b0;
        tick();
        start = 1'b1;
        desc_ptr = 32'h100;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("rstmid_arvalid_pre", arvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_arvalid", arvalid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_araddr", araddr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
